// File: rtl/dep_issue_scheduler_if.sv
// ============================================================================
// Module   : dep_issue_scheduler_if
// Brief    : Allocate / issue / complete bundle of the dependency issue scheduler.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dep_issue_scheduler_if #(
    parameter int BS = 32
);
    localparam int IW = $clog2(BS);

    logic          alloc_valid;
    logic          alloc_ready;
    logic [0:BS-1] alloc_dept;
    logic [IW-1:0] alloc_index;
    logic          issue_valid;
    logic          issue_ready;
    logic [IW-1:0] issue_index;
    logic          complete_valid;
    logic [IW-1:0] complete_index;
    logic [IW:0]   count;

    modport master (
        output alloc_valid, alloc_dept, issue_ready, complete_valid, complete_index,
        input  alloc_ready, alloc_index, issue_valid, issue_index, count
    );

    modport slave (
        input  alloc_valid, alloc_dept, issue_ready, complete_valid, complete_index,
        output alloc_ready, alloc_index, issue_valid, issue_index, count
    );
endinterface

`default_nettype wire

// File: rtl/dep_issue_scheduler.sv
// ============================================================================
// Module   : dep_issue_scheduler
// Brief    : BS x BS dependency matrix; issues oldest ready slot, retires in order.
//            Optional SCHED_ERR_CHK_EN adds sticky err / err_code outputs.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dep_issue_scheduler #(
    parameter  int BS = 32,
    localparam int IW = $clog2(BS)
) (
    input  wire                   clk,
    input  wire                   rst,
`ifdef SCHED_ERR_CHK_EN
    output logic                  err,
    output logic [1:0]            err_code,
`endif
    dep_issue_scheduler_if.slave  bus
);

    localparam logic [IW:0] C_FULL = (IW+1)'(BS);

    logic [0:BS-1] r_valid;
    logic [0:BS-1] r_issued;
    logic [0:BS-1] r_done;
    logic [0:BS-1] r_dep [BS];
    logic [IW-1:0] r_head;
    logic [IW-1:0] r_tail;
    logic [IW:0]   r_count;

    logic          w_alloc_ready;
    logic          w_alloc_fire;
    logic          w_issue_valid;
    logic [IW-1:0] w_issue_idx;
    logic          w_issue_fire;
    logic          w_cmp_legal;
    logic [0:BS-1] w_cmp_onehot;
    logic [0:BS-1] w_live;
    logic [0:BS-1] w_ready;
    logic          w_retire;
    logic [IW-1:0] w_scan;

    assign w_alloc_ready = (r_count != C_FULL);
    assign w_alloc_fire  = bus.alloc_valid & w_alloc_ready;
    assign w_issue_fire  = w_issue_valid & bus.issue_ready;
    assign w_retire      = r_valid[r_head] & r_done[r_head];

    // Completion of an unissued, already-done or empty slot is dropped.
    assign w_cmp_legal = bus.complete_valid
                       & r_valid[bus.complete_index]
                       & r_issued[bus.complete_index]
                       & ~r_done[bus.complete_index];

    always_comb begin
        w_cmp_onehot = '0;
        if (w_cmp_legal) begin
            w_cmp_onehot[bus.complete_index] = 1'b1;
        end
    end

    // Producers still outstanding after this cycle; filters stale and self bits.
    assign w_live = r_valid & ~r_done & ~w_cmp_onehot;

    always_comb begin
        w_ready = '0;
        for (int i = 0; i < BS; i++) begin
            w_ready[i] = r_valid[i] & ~r_issued[i] & ~(|r_dep[i]);
        end
    end

    // Walk from youngest to oldest offset so the oldest ready slot wins.
    always_comb begin
        w_issue_valid = 1'b0;
        w_issue_idx   = '0;
        w_scan        = '0;
        for (int k = BS - 1; k >= 0; k--) begin
            w_scan = r_head + IW'(k);
            if (w_ready[w_scan]) begin
                w_issue_valid = 1'b1;
                w_issue_idx   = w_scan;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid  <= '0;
            r_issued <= '0;
            r_done   <= '0;
            r_head   <= '0;
            r_tail   <= '0;
            r_count  <= '0;
            for (int i = 0; i < BS; i++) begin
                r_dep[i] <= '0;
            end
        end else begin
            if (w_cmp_legal) begin
                r_done[bus.complete_index] <= 1'b1;
                for (int i = 0; i < BS; i++) begin
                    r_dep[i][bus.complete_index] <= 1'b0;
                end
            end
            if (w_issue_fire) begin
                r_issued[w_issue_idx] <= 1'b1;
            end
            if (w_retire) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + 1'b1;
            end
            // The tail slot is never valid here, so it cannot collide with the updates above.
            if (w_alloc_fire) begin
                r_valid[r_tail]  <= 1'b1;
                r_issued[r_tail] <= 1'b0;
                r_done[r_tail]   <= 1'b0;
                r_dep[r_tail]    <= bus.alloc_dept & w_live;
                r_tail           <= r_tail + 1'b1;
            end
            r_count <= r_count + (IW+1)'(w_alloc_fire) - (IW+1)'(w_retire);
        end
    end

    assign bus.alloc_ready = w_alloc_ready;
    assign bus.alloc_index = r_tail;
    assign bus.issue_valid = w_issue_valid;
    assign bus.issue_index = w_issue_idx;
    assign bus.count       = r_count;

`ifdef SCHED_ERR_CHK_EN
    logic       r_err;
    logic [1:0] r_err_code;
    logic       w_bad_cmp;
    logic       w_full_alloc;

    assign w_bad_cmp    = bus.complete_valid & ~w_cmp_legal;
    assign w_full_alloc = bus.alloc_valid & ~w_alloc_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err      <= 1'b0;
            r_err_code <= 2'd0;
        end else if (!r_err && (w_bad_cmp || w_full_alloc)) begin
            r_err      <= 1'b1;
            r_err_code <= w_bad_cmp ? 2'd1 : 2'd2;
        end
    end

    assign err      = r_err;
    assign err_code = r_err_code;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dep_issue_scheduler.sv
// ============================================================================
// Module   : tb_dep_issue_scheduler
// Brief    : Directed vector bench for dep_issue_scheduler at BS=4.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dep_issue_scheduler;

    localparam int BS = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    dep_issue_scheduler_if #(.BS(BS)) bus ();

`ifdef SCHED_ERR_CHK_EN
    logic       err;
    logic [1:0] err_code;
`endif

    dep_issue_scheduler #(.BS(BS)) dut (
        .clk      (clk),
        .rst      (rst),
`ifdef SCHED_ERR_CHK_EN
        .err      (err),
        .err_code (err_code),
`endif
        .bus      (bus)
    );

    typedef struct {
        logic       rst;
        logic       av;
        logic [0:3] dept;
        logic       ir;
        logic       cv;
        logic [1:0] ci;
        logic       e_ar;
        logic [1:0] e_ai;
        logic       e_iv;
        logic [1:0] e_ii;
        logic [2:0] e_cnt;
    } vec_t;

    localparam int NV = 29;
    vec_t vecs [NV];

    int n_vec = 0;
    int n_bad = 0;

    function automatic logic [8:0] outs();
        return {bus.alloc_ready, bus.alloc_index, bus.issue_valid, bus.issue_index, bus.count};
    endfunction

    task automatic check(input string name, input logic [8:0] got, input logic [8:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    initial begin
        // Outputs packed as {alloc_ready, alloc_index, issue_valid, issue_index, count}.
        //          rst  av   dept     ir   cv   ci     ar   ai     iv   ii     cnt
        vecs[0]  = '{1'b0,1'b1,4'b0000,1'b1,1'b0,2'd0, 1'b1,2'd0, 1'b0,2'd0, 3'd0};
        vecs[1]  = '{1'b0,1'b1,4'b1000,1'b1,1'b0,2'd0, 1'b1,2'd1, 1'b1,2'd0, 3'd1};
        vecs[2]  = '{1'b0,1'b0,4'b0000,1'b1,1'b1,2'd0, 1'b1,2'd2, 1'b0,2'd0, 3'd2};
        vecs[3]  = '{1'b0,1'b0,4'b0000,1'b1,1'b0,2'd0, 1'b1,2'd2, 1'b1,2'd1, 3'd2};
        vecs[4]  = '{1'b0,1'b0,4'b0000,1'b0,1'b1,2'd1, 1'b1,2'd2, 1'b0,2'd0, 3'd1};
        vecs[5]  = '{1'b0,1'b0,4'b0000,1'b0,1'b0,2'd0, 1'b1,2'd2, 1'b0,2'd0, 3'd1};
        vecs[6]  = '{1'b1,1'b0,4'b0000,1'b0,1'b0,2'd0, 1'b1,2'd2, 1'b0,2'd0, 3'd0};
        vecs[7]  = '{1'b0,1'b1,4'b0000,1'b0,1'b0,2'd0, 1'b1,2'd0, 1'b0,2'd0, 3'd0};
        vecs[8]  = '{1'b0,1'b1,4'b0000,1'b0,1'b0,2'd0, 1'b1,2'd1, 1'b1,2'd0, 3'd1};
        vecs[9]  = '{1'b0,1'b1,4'b0000,1'b0,1'b0,2'd0, 1'b1,2'd2, 1'b1,2'd0, 3'd2};
        vecs[10] = '{1'b0,1'b1,4'b0000,1'b0,1'b0,2'd0, 1'b1,2'd3, 1'b1,2'd0, 3'd3};
        vecs[11] = '{1'b0,1'b0,4'b0000,1'b1,1'b0,2'd0, 1'b0,2'd0, 1'b1,2'd0, 3'd4};
        vecs[12] = '{1'b0,1'b0,4'b0000,1'b1,1'b0,2'd0, 1'b0,2'd0, 1'b1,2'd1, 3'd4};
        vecs[13] = '{1'b0,1'b0,4'b0000,1'b1,1'b0,2'd0, 1'b0,2'd0, 1'b1,2'd2, 3'd4};
        vecs[14] = '{1'b0,1'b0,4'b0000,1'b1,1'b0,2'd0, 1'b0,2'd0, 1'b1,2'd3, 3'd4};
        vecs[15] = '{1'b0,1'b0,4'b0000,1'b1,1'b1,2'd0, 1'b0,2'd0, 1'b0,2'd0, 3'd4};
        vecs[16] = '{1'b0,1'b0,4'b0000,1'b0,1'b0,2'd0, 1'b0,2'd0, 1'b0,2'd0, 3'd4};
        vecs[17] = '{1'b0,1'b1,4'b0010,1'b0,1'b1,2'd2, 1'b1,2'd0, 1'b0,2'd0, 3'd3};
        vecs[18] = '{1'b0,1'b0,4'b0000,1'b1,1'b0,2'd0, 1'b0,2'd1, 1'b1,2'd0, 3'd4};
        vecs[19] = '{1'b0,1'b0,4'b0000,1'b0,1'b1,2'd1, 1'b0,2'd1, 1'b0,2'd0, 3'd4};
        vecs[20] = '{1'b0,1'b0,4'b0000,1'b0,1'b0,2'd0, 1'b0,2'd1, 1'b0,2'd0, 3'd4};
        vecs[21] = '{1'b0,1'b0,4'b0000,1'b0,1'b0,2'd0, 1'b1,2'd1, 1'b0,2'd0, 3'd3};
        vecs[22] = '{1'b0,1'b1,4'b0011,1'b0,1'b0,2'd0, 1'b1,2'd1, 1'b0,2'd0, 3'd2};
        vecs[23] = '{1'b0,1'b0,4'b0000,1'b0,1'b1,2'd3, 1'b1,2'd2, 1'b0,2'd0, 3'd3};
        vecs[24] = '{1'b0,1'b0,4'b0000,1'b0,1'b1,2'd1, 1'b1,2'd2, 1'b1,2'd1, 3'd3};
        vecs[25] = '{1'b0,1'b0,4'b0000,1'b1,1'b1,2'd2, 1'b1,2'd2, 1'b1,2'd1, 3'd2};
        vecs[26] = '{1'b0,1'b1,4'b0000,1'b0,1'b0,2'd0, 1'b1,2'd2, 1'b0,2'd0, 3'd2};
        vecs[27] = '{1'b1,1'b0,4'b0000,1'b0,1'b0,2'd0, 1'b1,2'd3, 1'b1,2'd2, 3'd3};
        vecs[28] = '{1'b0,1'b0,4'b0000,1'b0,1'b0,2'd0, 1'b1,2'd0, 1'b0,2'd0, 3'd0};

        bus.alloc_valid    = 1'b0;
        bus.alloc_dept     = '0;
        bus.issue_ready    = 1'b0;
        bus.complete_valid = 1'b0;
        bus.complete_index = '0;
        rst                = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Each vector: outputs reflect registered state, then this cycle's inputs are driven.
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            check($sformatf("vec%0d", i), outs(),
                  {vecs[i].e_ar, vecs[i].e_ai, vecs[i].e_iv, vecs[i].e_ii, vecs[i].e_cnt});
            rst                = vecs[i].rst;
            bus.alloc_valid    = vecs[i].av;
            bus.alloc_dept     = vecs[i].dept;
            bus.issue_ready    = vecs[i].ir;
            bus.complete_valid = vecs[i].cv;
            bus.complete_index = vecs[i].ci;
        end

        // Issue and completion of the same slot in one cycle: completion must be dropped.
        @(negedge clk);
        bus.alloc_valid = 1'b1;
        bus.alloc_dept  = '0;
        @(negedge clk);
        bus.alloc_valid = 1'b0;
        check("same_cyc_offer", {7'd0, bus.issue_valid, bus.issue_index[0]}, 9'b0_0000_0010);
        bus.issue_ready    = 1'b1;
        bus.complete_valid = 1'b1;
        bus.complete_index = 2'd0;
        @(negedge clk);
        bus.issue_ready    = 1'b0;
        bus.complete_valid = 1'b0;
        check("same_cyc_issued", {5'd0, bus.issue_valid, bus.count}, {5'd0, 1'b0, 3'd1});
`ifdef SCHED_ERR_CHK_EN
        check("err_bad_cmp", {6'd0, err, err_code}, {6'd0, 1'b1, 2'd1});
`endif
        @(negedge clk);
        check("same_cyc_no_retire", {6'd0, bus.count}, {6'd0, 3'd1});
        bus.complete_valid = 1'b1;
        bus.complete_index = 2'd0;
        @(negedge clk);
        bus.complete_valid = 1'b0;
        check("legal_cmp_done", {6'd0, bus.count}, {6'd0, 3'd1});
        @(negedge clk);
        check("legal_cmp_retired", outs(), {1'b1, 2'd1, 1'b0, 2'd0, 3'd0});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/dep_issue_scheduler.md
Name: dep_issue_scheduler

Overview:
- Consumer end of the instruction dependency tracker. Receives the per-slot dependency vector produced for each newly buffered instruction and holds it in a BS x BS dependency matrix.
- Issues the oldest instruction whose dependencies have all resolved. Clears dependency columns on completion, then retires slots in order so they can be reallocated.
- Sits between the dependency tracker (allocation side) and the execution units (issue/complete side). Its alloc_index drives the tracker's buffer_index.

Parameters:
- BS, 32, buffer slots; power of two, >= 2.
- IW, $clog2(BS), slot index width (derived; do not override).

Ports:
- clk  in  1  clock
- rst  in  1  reset
- alloc_valid  in  1  new instruction present
- alloc_ready  out  1  free slot available
- alloc_dept  in  BS  dependency vector; bit j = depends on slot j; MSB-first order [0:BS-1]
- alloc_index  out  IW  slot that the next allocation will occupy (tail)
- issue_valid  out  1  a ready instruction is offered
- issue_ready  in  1  execution unit accepts
- issue_index  out  IW  slot being offered
- complete_valid  in  1  an issued instruction finished
- complete_index  in  IW  slot that finished
- count  out  IW+1  occupied slots

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk. Reset clears all state: valid, issued, done, dep matrix, head=0, tail=0, count=0. Resulting outputs: alloc_ready=1, alloc_index=0, issue_valid=0, issue_index=0, count=0. Reset mid-operation flushes every entry; in-flight completions are lost.
- Per-slot state: valid, issued, done, dep row [BS].
- Allocation fires on alloc_valid & alloc_ready:
  - slot tail gets valid=1, issued=0, done=0.
  - row = alloc_dept & valid_live, where valid_live = valid & ~done & ~(completing slot this cycle). This masks stale bits and the self bit.
  - tail increments mod BS.
- alloc_ready = (count != BS), from registered count. A slot freed by retirement this cycle cannot be reused until the next cycle.
- Ready condition for slot i: valid & ~issued & (row == 0).
- issue_valid is combinational from registered state only; it never depends on issue_ready. issue_index is the first ready slot scanning circularly from head (oldest first). issue_index holds 0 when issue_valid=0.
- Issue fires on issue_valid & issue_ready: sets issued[issue_index]. At most one issue per cycle.
- An entry allocated in cycle N is earliest issuable in cycle N+1.
- Completion on complete_valid, legal only if slot valid & issued & ~done:
  - sets done.
  - clears column complete_index in every row (registered). Dependents become ready the next cycle.
  - Illegal completions are ignored with no state change.
- Retirement: if valid[head] & done[head], clear valid[head] and increment head mod BS. At most one retirement per cycle; in-order.
- count = count + alloc_fire - retire_fire.
- Simultaneous events in one cycle (alloc, issue, complete, retire) are all legal and independent.
- Issue and completion of the same slot in the same cycle is illegal: completion is ignored because issued is not yet set.
- Head/tail wrap at BS; head==tail disambiguated by count (0 = empty, BS = full).

Optional Feature:
- Macro SCHED_ERR_CHK_EN.
- Defined:
  - adds output err (1 bit, reset 0) and output err_code (2 bits, reset 0).
  - err is set sticky on an illegal completion (code 1) or alloc_valid while full (code 2). First error code is kept; cleared only by rst.
- Undefined: no ports added; illegal events are silently ignored as specified above.

Test Plan:
- BS=4, after reset -> alloc_ready=1, issue_valid=0, count=0, alloc_index=0.
- Alloc A (dept 0000) to slot0, then B (dept 1000, depends on slot0) to slot1, issue_ready=1 -> slot0 issued first; issue_valid=0 while B is blocked. complete slot0 -> B issued the following cycle with issue_index=1; slot0 retires, count 2->1.
- Fill 4 slots with zero deps, issue_ready=0 -> count=4, alloc_ready=0. Complete nothing; raise issue_ready -> issues in order 0,1,2,3. Complete 0 -> head=1, alloc_ready=1, alloc_index wraps to 0.
- Alloc C with dept bit for slot2 in the same cycle slot2 completes -> C's row has bit2 clear; C issuable the next cycle.
- complete_valid on a slot that is unissued or empty -> no state change; with SCHED_ERR_CHK_EN, err=1 and err_code=1. Assert rst mid-stream with 3 entries -> next cycle count=0, issue_valid=0, alloc_index=0.
